// File: rtl/vending_pkg.sv
// Shared definitions for the multi-product vending controller:
// coin codes, coin-to-cents mapping and the controller state type.
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_25   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    function automatic logic [4:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 5'd5;
            COIN_10: return 5'd10;
            COIN_25: return 5'd25;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_change_gen.sv
// Change generator: holds the refund remainder and pays it out greedily,
// one coin per valid/ready handshake. done marks the final transfer.
module vm_change_gen
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_value,
    input  logic                change_ready,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic [CREDIT_W-1:0] remainder,
    output logic                done
);

    logic [CREDIT_W-1:0] rem_q;
    logic [1:0]          greedy;
    logic [CREDIT_W-1:0] coin_cents;
    logic                xfer;

    always_comb begin
        greedy = COIN_NONE;
        if (rem_q >= CREDIT_W'(25))
            greedy = COIN_25;
        else if (rem_q >= CREDIT_W'(10))
            greedy = COIN_10;
        else if (rem_q >= CREDIT_W'(5))
            greedy = COIN_5;
    end

    assign coin_cents   = CREDIT_W'(coin_value(greedy));
    assign change_valid = enable && (rem_q != '0);
    assign change_coin  = change_valid ? greedy : COIN_NONE;
    assign xfer         = change_valid && change_ready;
    assign done         = xfer && (rem_q == coin_cents);
    assign remainder    = rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rem_q <= '0;
        else if (load)
            rem_q <= load_value;
        else if (xfer)
            rem_q <= rem_q - coin_cents;
    end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: credit accumulation, per-item stock,
// vend pulse and greedy change. SALES_AUDIT_EN adds sales_total/vend_count.
//
// state  | meaning
// IDLE   | no credit, accepting coins
// CREDIT | credit > 0, accepting coins, select or cancel
// VEND   | single-cycle dispense pulse
// CHANGE | paying out the remainder through vm_change_gen
module vending_machine_multi
    import vending_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 100,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     coin,
    input  logic                           select,
    input  logic [$clog2(NUM_ITEMS)-1:0]   sel_item,
    input  logic                           cancel,
    input  logic [NUM_ITEMS*CREDIT_W-1:0]  price_tbl,
    input  logic                           restock,
    input  logic [$clog2(NUM_ITEMS)-1:0]   restock_item,
    input  logic                           change_ready,
    output logic                           vend,
    output logic [$clog2(NUM_ITEMS)-1:0]   vend_item,
    output logic                           coin_reject,
    output logic                           change_valid,
    output logic [1:0]                     change_coin,
    output logic [CREDIT_W-1:0]            credit,
    output logic [NUM_ITEMS-1:0]           sold_out,
    output logic                           busy
`ifdef SALES_AUDIT_EN
    ,
    output logic [23:0]                    sales_total,
    output logic [15:0]                    vend_count
`endif
);

    localparam int IW = $clog2(NUM_ITEMS);

    state_t              state, state_nx;
    logic [CREDIT_W-1:0] credit_q;
    logic [STOCK_W-1:0]  stock [NUM_ITEMS];
    logic [CREDIT_W-1:0] price [NUM_ITEMS];
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W:0]   credit_sum;
    logic [IW-1:0]       vend_item_q;
    logic                accepting, cancel_acc, select_acc, coin_acc;
    logic                load_change, change_done;
    logic [CREDIT_W-1:0] remainder;

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
        assign price[i]    = price_tbl[i*CREDIT_W +: CREDIT_W];
        assign sold_out[i] = (stock[i] == '0);
    end

    // Same-cycle priority: cancel over select over coin.
    assign sel_price   = price[sel_item];
    assign accepting   = (state == IDLE) || (state == CREDIT);
    assign cancel_acc  = (state == CREDIT) && cancel;
    assign select_acc  = accepting && !cancel_acc && select &&
                         (sel_price <= credit_q) && (stock[sel_item] != '0);
    assign credit_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin));
    assign coin_acc    = accepting && !cancel_acc && !select_acc && (coin != COIN_NONE) &&
                         (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign load_change = cancel_acc || ((state == VEND) && (credit_q != '0));

    vm_change_gen #(.CREDIT_W(CREDIT_W)) u_change (
        .clk          (clk),
        .rst          (rst),
        .enable       (state == CHANGE),
        .load         (load_change),
        .load_value   (credit_q),
        .change_ready (change_ready),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .remainder    (remainder),
        .done         (change_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (coin_acc) state_nx = CREDIT;
            CREDIT:  if (cancel_acc) state_nx = CHANGE;
                     else if (select_acc) state_nx = VEND;
            VEND:    state_nx = (credit_q != '0) ? CHANGE : IDLE;
            CHANGE:  if (change_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        vend      = (state == VEND);
        busy      = (state == VEND) || (state == CHANGE);
        credit    = (state == CHANGE) ? remainder : credit_q;
        vend_item = vend_item_q;
    end

    // credit_q holds the remainder during VEND, then hands it to the change generator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q    <= '0;
            coin_reject <= 1'b0;
            vend_item_q <= '0;
        end else begin
            coin_reject <= (coin != COIN_NONE) && !coin_acc;
            if (select_acc)
                vend_item_q <= sel_item;
            if (cancel_acc || (state == VEND))
                credit_q <= '0;
            else if (select_acc)
                credit_q <= credit_q - sel_price;
            else if (coin_acc)
                credit_q <= credit_sum[CREDIT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ITEMS; i++)
                stock[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (restock && (restock_item == IW'(i)))
                    stock[i] <= STOCK_W'(STOCK_INIT);
                else if (select_acc && (sel_item == IW'(i)))
                    stock[i] <= stock[i] - STOCK_W'(1);
            end
        end
    end

`ifdef SALES_AUDIT_EN
    logic [24:0] sales_sum;
    assign sales_sum = {1'b0, sales_total} + 25'(sel_price);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sales_total <= '0;
            vend_count  <= '0;
        end else if (select_acc) begin
            sales_total <= sales_sum[24] ? 24'hFFFFFF : sales_sum[23:0];
            vend_count  <= vend_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vending_machine_multi.sv
// Self-checking bench for vending_machine_multi: directed scenarios plus a
// randomized coin/select/cancel mix against a cents-level reference model.
module tb_vending_machine_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  coin;
    logic        select;
    logic [1:0]  sel_item;
    logic        cancel;
    logic [31:0] price_tbl;
    logic        restock;
    logic [1:0]  restock_item;
    logic        change_ready;
    logic        vend;
    logic [1:0]  vend_item;
    logic        coin_reject;
    logic        change_valid;
    logic [1:0]  change_coin;
    logic [7:0]  credit;
    logic [3:0]  sold_out;
    logic        busy;
`ifdef SALES_AUDIT_EN
    logic [23:0] sales_total;
    logic [15:0] vend_count;
`endif

    int prices [4] = '{35, 15, 5, 50};
    assign price_tbl = {8'd50, 8'd5, 8'd15, 8'd35};

    vending_machine_multi dut (
        .clk          (clk),
        .rst          (rst),
        .coin         (coin),
        .select       (select),
        .sel_item     (sel_item),
        .cancel       (cancel),
        .price_tbl    (price_tbl),
        .restock      (restock),
        .restock_item (restock_item),
        .change_ready (change_ready),
        .vend         (vend),
        .vend_item    (vend_item),
        .coin_reject  (coin_reject),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .credit       (credit),
        .sold_out     (sold_out),
        .busy         (busy)
`ifdef SALES_AUDIT_EN
        ,
        .sales_total  (sales_total),
        .vend_count   (vend_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int m_credit;
    int m_stock [4];

    function automatic int cents(input logic [1:0] c);
        case (c)
            2'b01:   return 5;
            2'b10:   return 10;
            2'b11:   return 25;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] model_sold_out();
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = (m_stock[i] == 0);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 10;
    endtask

    task automatic idle_inputs();
        coin = 2'b00; select = 1'b0; sel_item = 2'd0; cancel = 1'b0;
        restock = 1'b0; restock_item = 2'd0; change_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic insert(input logic [1:0] c);
        int  v;
        bit  exp_rej;
        coin = c;
        tick();
        coin = 2'b00;
        v = cents(c);
        exp_rej = (v != 0) && (m_credit + v > 100);
        if (!exp_rej) m_credit += v;
        checks++;
        if (coin_reject !== exp_rej) $display("FAIL insert_reject got=%0d exp=%0d", coin_reject, exp_rej);
        else passed++;
        checks++;
        if (credit !== 8'(m_credit)) $display("FAIL insert_credit got=%0d exp=%0d", credit, m_credit);
        else passed++;
    endtask

    // Pays out `total` and checks each coin against a greedy breakdown.
    task automatic collect_change(input int total, input int ready_pct);
        int exp_q [$];
        int rem;
        int idx;
        int cyc;
        rem = total;
        while (rem >= 25) begin exp_q.push_back(25); rem -= 25; end
        while (rem >= 10) begin exp_q.push_back(10); rem -= 10; end
        while (rem >= 5)  begin exp_q.push_back(5);  rem -= 5;  end
        rem = total;
        idx = 0;
        cyc = 0;
        while (idx < exp_q.size() && cyc < 200) begin
            change_ready = ($urandom_range(99) < ready_pct);
            checks++;
            if (change_valid !== 1'b1 || cents(change_coin) != exp_q[idx] || credit !== 8'(rem))
                $display("FAIL change_coin valid=%0d coin=%0d credit=%0d exp_coin=%0d exp_credit=%0d",
                         change_valid, cents(change_coin), credit, exp_q[idx], rem);
            else passed++;
            tick();
            if (change_ready) begin
                rem -= exp_q[idx];
                idx++;
            end
            cyc++;
        end
        change_ready = 1'b0;
        checks++;
        if (idx < exp_q.size()) $display("FAIL change_timeout got=%0d exp=%0d coins", idx, exp_q.size());
        else passed++;
        checks++;
        if (change_valid !== 1'b0 || busy !== 1'b0 || credit !== 8'd0)
            $display("FAIL change_end valid=%0d busy=%0d credit=%0d exp=0", change_valid, busy, credit);
        else passed++;
        m_credit = 0;
    endtask

    task automatic try_select(input int item, input logic [1:0] c, input int ready_pct);
        bit ok;
        int rem;
        int v;
        bit exp_rej;
        ok = (prices[item] <= m_credit) && (m_stock[item] > 0);
        select = 1'b1; sel_item = 2'(item); coin = c;
        tick();
        select = 1'b0; coin = 2'b00;
        if (ok) begin
            checks++;
            if (vend !== 1'b1 || vend_item !== 2'(item) || busy !== 1'b1)
                $display("FAIL vend_pulse vend=%0d item=%0d busy=%0d exp_item=%0d", vend, vend_item, busy, item);
            else passed++;
            checks++;
            if (coin_reject !== (c != 2'b00)) $display("FAIL select_coin_reject got=%0d exp=%0d", coin_reject, c != 2'b00);
            else passed++;
            m_stock[item]--;
            rem = m_credit - prices[item];
            m_credit = 0;
            tick();
            checks++;
            if (vend !== 1'b0) $display("FAIL vend_one_cycle got=%0d exp=0", vend);
            else passed++;
            if (rem > 0) collect_change(rem, ready_pct);
            else begin
                checks++;
                if (busy !== 1'b0 || credit !== 8'd0) $display("FAIL vend_exact busy=%0d credit=%0d exp=0", busy, credit);
                else passed++;
            end
        end else begin
            v = cents(c);
            exp_rej = (v != 0) && (m_credit + v > 100);
            if (!exp_rej) m_credit += v;
            checks++;
            if (vend !== 1'b0 || busy !== 1'b0 || credit !== 8'(m_credit) || coin_reject !== exp_rej)
                $display("FAIL select_ignored vend=%0d busy=%0d credit=%0d rej=%0d exp_credit=%0d exp_rej=%0d",
                         vend, busy, credit, coin_reject, m_credit, exp_rej);
            else passed++;
        end
        checks++;
        if (sold_out !== model_sold_out()) $display("FAIL sold_out got=%0h exp=%0h", sold_out, model_sold_out());
        else passed++;
    endtask

    task automatic do_cancel(input logic [1:0] c, input int ready_pct);
        int amt;
        amt = m_credit;
        cancel = 1'b1; coin = c;
        tick();
        cancel = 1'b0; coin = 2'b00;
        checks++;
        if (coin_reject !== (c != 2'b00)) $display("FAIL cancel_coin_reject got=%0d exp=%0d", coin_reject, c != 2'b00);
        else passed++;
        collect_change(amt, ready_pct);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        checks++;
        if (credit !== 8'd0 || vend !== 1'b0 || coin_reject !== 1'b0 || change_valid !== 1'b0)
            $display("FAIL reset_outputs credit=%0d vend=%0d rej=%0d cv=%0d exp=0", credit, vend, coin_reject, change_valid);
        else passed++;
        checks++;
        if (change_coin !== 2'b00 || vend_item !== 2'd0 || busy !== 1'b0 || sold_out !== 4'h0)
            $display("FAIL reset_misc coin=%0d item=%0d busy=%0d sold=%0h exp=0", change_coin, vend_item, busy, sold_out);
        else passed++;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_exact_vend();
        insert(2'b11);
        insert(2'b10);
        try_select(0, 2'b00, 100);
    endtask

    task automatic test_change();
        insert(2'b11);
        insert(2'b11);
        try_select(1, 2'b00, 100);
    endtask

    task automatic test_reject_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || credit !== 8'd0) $display("FAIL cancel_idle busy=%0d credit=%0d exp=0", busy, credit);
        else passed++;
        insert(2'b11); insert(2'b11); insert(2'b11); insert(2'b10); insert(2'b01);
        insert(2'b11);
        do_cancel(2'b00, 100);
    endtask

    task automatic test_backpressure();
        insert(2'b11); insert(2'b10); insert(2'b01);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            change_ready = 1'b0;
            coin = 2'b11;
            checks++;
            if (change_valid !== 1'b1 || change_coin !== 2'b11 || credit !== 8'd40)
                $display("FAIL hold_stable valid=%0d coin=%0d credit=%0d exp=1/3/40", change_valid, change_coin, credit);
            else passed++;
            tick();
            checks++;
            if (coin_reject !== 1'b1) $display("FAIL change_coin_reject got=%0d exp=1", coin_reject);
            else passed++;
        end
        coin = 2'b00;
        collect_change(40, 100);
    endtask

    task automatic test_sold_out_restock();
        while (m_stock[2] > 0) begin
            insert(2'b01);
            try_select(2, 2'b00, 100);
        end
        insert(2'b01);
        try_select(2, 2'b00, 100);
        do_cancel(2'b00, 100);
        restock = 1'b1; restock_item = 2'd2;
        tick();
        restock = 1'b0;
        m_stock[2] = 10;
        checks++;
        if (sold_out[2] !== 1'b0) $display("FAIL restock got=%0d exp=0", sold_out[2]);
        else passed++;
        // Restock colliding with a vend of the same item leaves a full stock.
        insert(2'b01);
        select = 1'b1; sel_item = 2'd2; restock = 1'b1; restock_item = 2'd2;
        tick();
        select = 1'b0; restock = 1'b0;
        checks++;
        if (vend !== 1'b1) $display("FAIL collide_vend got=%0d exp=1", vend);
        else passed++;
        m_credit = 0;
        tick();
        while (m_stock[2] > 0) begin
            insert(2'b01);
            try_select(2, 2'b00, 100);
        end
        restock = 1'b1; restock_item = 2'd2;
        tick();
        restock = 1'b0;
        m_stock[2] = 10;
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) insert(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0 && m_credit > 0)
                do_cancel(2'($urandom_range(0, 3)), 60);
            else begin
                try_select($urandom_range(0, 3), 2'($urandom_range(0, 3)), 60);
                if (m_credit > 0) do_cancel(2'b00, 60);
            end
        end
    endtask

    task automatic test_reset_mid_change();
        insert(2'b11); insert(2'b11); insert(2'b11);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        change_ready = 1'b0;
        tick();
        checks++;
        if (change_valid !== 1'b1) $display("FAIL pre_reset_change got=%0d exp=1", change_valid);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0 || change_coin !== 2'b00)
            $display("FAIL async_reset valid=%0d credit=%0d busy=%0d coin=%0d exp=0", change_valid, credit, busy, change_coin);
        else passed++;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        insert(2'b01);
        do_cancel(2'b00, 100);
    endtask

`ifdef SALES_AUDIT_EN
    task automatic test_audit();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            insert(2'b11);
            insert(2'b10);
            try_select(0, 2'b00, 100);
        end
        checks++;
        if (sales_total !== 24'd105 || vend_count !== 16'd3)
            $display("FAIL audit total=%0d count=%0d exp=105/3", sales_total, vend_count);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_exact_vend();
        test_change();
        test_reject_cancel();
        test_backpressure();
        test_sold_out_restock();
        test_reset_mid_change();
        test_random();
`ifdef SALES_AUDIT_EN
        test_audit();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
